// File: rtl/guess_history_buf.sv
// Turn-history buffer for the code-breaking game.
// Records guesses with feedback in play mode; browses them in browse mode.
module guess_history_buf #(
  parameter int PEGS  = 4,
  parameter int PEG_W = 3,
  parameter int DEPTH = 8,
  parameter int FB_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_select,
  input  logic [PEGS*PEG_W-1:0]      guess,
  input  logic [FB_W-1:0]            fb_black,
  input  logic [FB_W-1:0]            fb_white,
  output logic [PEGS*PEG_W-1:0]      sel_guess,
  output logic [FB_W-1:0]            sel_black,
  output logic [FB_W-1:0]            sel_white,
  output logic [$clog2(DEPTH)-1:0]   sel_turn,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sel_valid,
  output logic                       full,
  output logic                       last_turn,
  output logic                       store_ack
);

  localparam int GW = PEGS * PEG_W;
  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = GW + 2 * FB_W;

  typedef logic [EW-1:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   sel_turn_q, sel_turn_d;
  entry_t          sel_q, sel_d;
  logic            sel_valid_q, sel_valid_d;
  logic            full_q, full_d;
  logic            last_turn_q, last_turn_d;
  logic            store_ack_q, store_ack_d;

  logic            is_full;
  logic [TW-1:0]   newest;
  logic [TW-1:0]   wr_idx;
  entry_t          wdata;
  entry_t          rd;

  assign is_full = (count_q == CW'(DEPTH));
  assign newest  = (count_q == '0) ? '0 : TW'(count_q - CW'(1));
  assign wr_idx  = count_q[TW-1:0];
  assign wdata   = {guess, fb_black, fb_white};

  // Next-state: commit in play mode, selection stepping in browse mode.
  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    sel_turn_d  = newest;
    store_ack_d = 1'b0;
    if (!mode) begin
      if (btn_select && !is_full) begin
        mem_d[wr_idx] = wdata;
        count_d       = count_q + CW'(1);
        sel_turn_d    = wr_idx;
        store_ack_d   = 1'b1;
      end
    end else begin
      sel_turn_d = sel_turn_q;
      if (count_q == '0) begin
        sel_turn_d = '0;
      end else if (btn_up && !btn_down) begin
        if (sel_turn_q < newest)
          sel_turn_d = sel_turn_q + TW'(1);
      end else if (btn_down && !btn_up) begin
        if (sel_turn_q != '0)
          sel_turn_d = sel_turn_q - TW'(1);
      end
    end
    rd          = mem_d[sel_turn_d];
    sel_valid_d = (count_d != '0);
    sel_d       = sel_valid_d ? rd : '0;
    full_d      = (count_d == CW'(DEPTH));
    last_turn_d = !mode && (count_d == CW'(DEPTH - 1));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      count_q     <= '0;
      sel_turn_q  <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      full_q      <= 1'b0;
      last_turn_q <= 1'b0;
      store_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
      count_q     <= count_d;
      sel_turn_q  <= sel_turn_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      full_q      <= full_d;
      last_turn_q <= last_turn_d;
      store_ack_q <= store_ack_d;
    end
  end

  assign sel_guess = sel_q[EW-1 -: GW];
  assign sel_black = sel_q[2*FB_W-1 -: FB_W];
  assign sel_white = sel_q[FB_W-1:0];
  assign sel_turn  = sel_turn_q;
  assign count     = count_q;
  assign sel_valid = sel_valid_q;
  assign full      = full_q;
  assign last_turn = last_turn_q;
  assign store_ack = store_ack_q;

endmodule
